// File: rtl/armish_datapath_mc.sv
// Multi-cycle ARMish datapath: register file, signed barrel shifter on Rm, ALU with NZCV flags and conditional execution.
// Define ARMISH_MUL_EN to build the iterative radix-2 multiplier; without it op 8 behaves as a NOP.
module armish_datapath_mc #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid,
    output logic                          ready,
    input  logic [3:0]                    op,
    input  logic [3:0]                    cond,
    input  logic                          set_flags,
    input  logic signed [$clog2(WIDTH):0] sh,
    input  logic [$clog2(NREGS)-1:0]      d,
    input  logic [$clog2(NREGS)-1:0]      n,
    input  logic [$clog2(NREGS)-1:0]      m,
    input  logic [WIDTH-1:0]              imm,
    output logic [WIDTH-1:0]              out,
    output logic                          wb,
    output logic [3:0]                    nzcv,
    output logic                          busy
);

    localparam int SEL_W = $clog2(NREGS);
    localparam int SH_W  = $clog2(WIDTH) + 1;
    localparam int SHM_W = SH_W + 1;
    localparam logic [SHM_W-1:0] WIDTH_SH = SHM_W'(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_ORR   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_EOR   = 4'd4;
    localparam logic [3:0] OP_B_NEG = 4'd5;
    localparam logic [3:0] OP_B_INV = 4'd6;
    localparam logic [3:0] OP_B_PAS = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_MOVI  = 4'd9;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic fn, fz, fc, fv;
        logic r;
        {fn, fz, fc, fv} = f;
        case (c)
            4'd0:    r = fz;
            4'd1:    r = ~fz;
            4'd2:    r = fc;
            4'd3:    r = ~fc;
            4'd4:    r = fn;
            4'd5:    r = ~fn;
            4'd6:    r = fv;
            4'd7:    r = ~fv;
            4'd8:    r = fc & ~fz;
            4'd9:    r = ~fc | fz;
            4'd10:   r = (fn == fv);
            4'd11:   r = (fn != fv);
            4'd12:   r = ~fz & (fn == fv);
            4'd13:   r = fz | (fn != fv);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] out_q, out_d;
    logic             wb_q, wb_d;
    logic [3:0]       nzcv_q, nzcv_d;

    logic [WIDTH-1:0] a_s, rm_s, b_s;
    logic [SHM_W-1:0] sh_ext_s, sh_mag_s;
    logic [WIDTH-1:0] add_a_s, add_b_s;
    logic             add_cin_s, add_v_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_wr_s, alu_c_s, alu_v_s;
    logic             ready_s, busy_s, issue_s, pass_s;
    logic [SEL_W-1:0] wr_sel_s;

    assign a_s     = regs_q[n];
    assign rm_s    = regs_q[m];
    assign issue_s = valid && ready_s;
    assign pass_s  = cond_pass(cond, nzcv_q);

    // Barrel shifter: positive sh shifts left, negative sh is an arithmetic right shift
    always_comb begin
        sh_ext_s = {sh[SH_W-1], sh};
        sh_mag_s = sh_ext_s;
        b_s      = '0;
        if (sh[SH_W-1]) begin
            sh_mag_s = ~sh_ext_s + {{(SHM_W-1){1'b0}}, 1'b1};
            if (sh_mag_s >= WIDTH_SH) begin
                b_s = {WIDTH{rm_s[WIDTH-1]}};
            end else begin
                b_s = $signed(rm_s) >>> sh_mag_s;
            end
        end else begin
            if (sh_mag_s >= WIDTH_SH) begin
                b_s = '0;
            end else begin
                b_s = rm_s << sh_mag_s;
            end
        end
    end

    // Shared adder operand select; B_NEG is computed as 0 + ~B + 1
    always_comb begin
        add_a_s   = a_s;
        add_b_s   = b_s;
        add_cin_s = 1'b0;
        case (op)
            OP_SUB: begin
                add_b_s   = ~b_s;
                add_cin_s = 1'b1;
            end
            OP_B_NEG: begin
                add_a_s   = '0;
                add_b_s   = ~b_s;
                add_cin_s = 1'b1;
            end
            default: begin
                add_a_s   = a_s;
                add_b_s   = b_s;
                add_cin_s = 1'b0;
            end
        endcase
    end

    assign sum_s   = {1'b0, add_a_s} + {1'b0, add_b_s} + {{WIDTH{1'b0}}, add_cin_s};
    assign add_v_s = (add_a_s[WIDTH-1] == add_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != add_a_s[WIDTH-1]);

`ifdef ARMISH_MUL_EN
    logic mul_start_s;
`endif

    // ALU result, write enable and the C/V values each op produces
    always_comb begin
        alu_res_s = '0;
        alu_wr_s  = 1'b0;
        alu_c_s   = nzcv_q[1];
        alu_v_s   = nzcv_q[0];
`ifdef ARMISH_MUL_EN
        mul_start_s = 1'b0;
`endif
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_wr_s  = 1'b1;
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = add_v_s;
            end
            OP_B_NEG: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_wr_s  = 1'b1;
                alu_c_s   = sum_s[WIDTH];
            end
            OP_ORR:   begin alu_res_s = a_s | b_s; alu_wr_s = 1'b1; end
            OP_AND:   begin alu_res_s = a_s & b_s; alu_wr_s = 1'b1; end
            OP_EOR:   begin alu_res_s = a_s ^ b_s; alu_wr_s = 1'b1; end
            OP_B_INV: begin alu_res_s = ~b_s;      alu_wr_s = 1'b1; end
            OP_B_PAS: begin alu_res_s = b_s;       alu_wr_s = 1'b1; end
            OP_MOVI:  begin alu_res_s = imm;       alu_wr_s = 1'b1; end
            OP_MUL: begin
`ifdef ARMISH_MUL_EN
                mul_start_s = 1'b1;
`else
                alu_wr_s = 1'b0;
`endif
            end
            default: alu_wr_s = 1'b0;
        endcase
    end

`ifdef ARMISH_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] md_q, md_d;
    logic             mflags_q, mflags_d;
    logic             mul_go_s, mul_done_s;
    logic [WIDTH-1:0] mul_res_s;

    assign mul_go_s   = issue_s && pass_s && mul_start_s;
    assign mul_done_s = (state_q == S_MUL) && (cnt_q == CNT_ONE);
    assign mul_res_s  = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the last step lands when the counter reads 1
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = mul_go_s   ? S_MUL  : S_IDLE;
            S_MUL:   state_d = mul_done_s ? S_IDLE : S_MUL;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        if (state_q == S_MUL) begin
            ready_s = 1'b0;
            busy_s  = 1'b1;
        end else begin
            ready_s = 1'b1;
            busy_s  = 1'b0;
        end
    end

    // Multiplier operand latch and shift-and-add step
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        md_d     = md_q;
        mflags_d = mflags_q;
        if (state_q == S_MUL) begin
            acc_d    = mul_res_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_ONE;
        end else if (mul_go_s) begin
            acc_d    = '0;
            mcand_d  = a_s;
            mplier_d = b_s;
            cnt_d    = CNT_INIT;
            md_d     = d;
            mflags_d = set_flags;
        end else begin
            acc_d = acc_q;
        end
    end

    // Multiplier datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            md_q     <= '0;
            mflags_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            md_q     <= md_d;
            mflags_q <= mflags_d;
        end
    end
`else
    assign ready_s = 1'b1;
    assign busy_s  = 1'b0;
`endif

    // Writeback: a passing single-cycle op, or the multiplier finishing
    always_comb begin
        regs_d   = regs_q;
        out_d    = out_q;
        wb_d     = 1'b0;
        nzcv_d   = nzcv_q;
        wr_sel_s = d;
        if (issue_s && pass_s && alu_wr_s) begin
            regs_d[wr_sel_s] = alu_res_s;
            out_d            = alu_res_s;
            wb_d             = 1'b1;
            if (set_flags) begin
                nzcv_d = {alu_res_s[WIDTH-1], (alu_res_s == '0), alu_c_s, alu_v_s};
            end else begin
                nzcv_d = nzcv_q;
            end
        end
`ifdef ARMISH_MUL_EN
        else if (mul_done_s) begin
            wr_sel_s         = md_q;
            regs_d[wr_sel_s] = mul_res_s;
            out_d            = mul_res_s;
            wb_d             = 1'b1;
            if (mflags_q) begin
                nzcv_d = {mul_res_s[WIDTH-1], (mul_res_s == '0), nzcv_q[1:0]};
            end else begin
                nzcv_d = nzcv_q;
            end
        end
`endif
        else begin
            wb_d = 1'b0;
        end
    end

    // Architectural state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
            out_q  <= '0;
            wb_q   <= 1'b0;
            nzcv_q <= 4'b0000;
        end else begin
            regs_q <= regs_d;
            out_q  <= out_d;
            wb_q   <= wb_d;
            nzcv_q <= nzcv_d;
        end
    end

    assign ready = ready_s;
    assign busy  = busy_s;
    assign out   = out_q;
    assign wb    = wb_q;
    assign nzcv  = nzcv_q;

endmodule

// File: tb/tb_armish_datapath_mc.sv
// Directed self-checking bench for armish_datapath_mc (WIDTH=16, NREGS=8).
// Registers are observed by re-writing them onto themselves with B_PAS, sh=0.
module tb_armish_datapath_mc;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ORR = 4'd2, OP_AND = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4, OP_B_NEG = 4'd5, OP_B_INV = 4'd6, OP_B_PAS = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8, OP_MOVI = 4'd9;
    localparam logic [3:0] C_EQ = 4'd0, C_NE = 4'd1, C_AL = 4'd14;

    logic              clk, reset, valid, ready, set_flags, wb, busy;
    logic [3:0]        op, cond, nzcv;
    logic signed [4:0] sh;
    logic [2:0]        d, n, m;
    logic [15:0]       imm, dout;

    int n_cmp = 0;
    int n_bad = 0;

    armish_datapath_mc #(.WIDTH(16), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .valid(valid), .ready(ready), .op(op), .cond(cond),
        .set_flags(set_flags), .sh(sh), .d(d), .n(n), .m(m), .imm(imm),
        .out(dout), .wb(wb), .nzcv(nzcv), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic present(input logic [3:0] op_i, input logic [3:0] cond_i, input logic sf_i,
                           input logic signed [4:0] sh_i, input logic [2:0] d_i, input logic [2:0] n_i,
                           input logic [2:0] m_i, input logic [15:0] imm_i);
        valid = 1'b1; op = op_i; cond = cond_i; set_flags = sf_i; sh = sh_i;
        d = d_i; n = n_i; m = m_i; imm = imm_i;
    endtask

    task automatic issue(input logic [3:0] op_i, input logic [3:0] cond_i, input logic sf_i,
                         input logic signed [4:0] sh_i, input logic [2:0] d_i, input logic [2:0] n_i,
                         input logic [2:0] m_i, input logic [15:0] imm_i);
        @(negedge clk);
        present(op_i, cond_i, sf_i, sh_i, d_i, n_i, m_i, imm_i);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] r);
        issue(OP_B_PAS, C_AL, 1'b0, 5'b00000, r, r, r, 16'h0000);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        present(OP_MOVI, C_AL, 1'b1, 5'b00000, 3'd1, 3'd0, 3'd0, 16'h5555);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        present(OP_MOVI, C_AL, 1'b1, 5'b00000, 3'd1, 3'd0, 3'd0, 16'h5555);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", dout); end
        n_cmp++; if (wb !== 1'b0) begin n_bad++; $display("FAIL reset_wb: got %b want 0", wb); end
        n_cmp++; if (nzcv !== 4'b0000) begin n_bad++; $display("FAIL reset_nzcv: got %b want 0000", nzcv); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        read_reg(3'd1);
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL reset_drops_movi: got %h want 0000", dout); end
    endtask

    task automatic test_overflow;
        issue(OP_MOVI, C_AL, 1'b0, 5'b00000, 3'd1, 3'd0, 3'd0, 16'h7FFF);
        n_cmp++; if (dout !== 16'h7FFF) begin n_bad++; $display("FAIL movi_r1: got %h want 7fff", dout); end
        n_cmp++; if (wb !== 1'b1) begin n_bad++; $display("FAIL movi_r1_wb: got %b want 1", wb); end
        @(negedge clk);
        n_cmp++; if (wb !== 1'b0) begin n_bad++; $display("FAIL wb_pulse_len: got %b want 0", wb); end
        issue(OP_MOVI, C_AL, 1'b0, 5'b00000, 3'd2, 3'd0, 3'd0, 16'h0001);
        n_cmp++; if (dout !== 16'h0001 || wb !== 1'b1) begin n_bad++; $display("FAIL movi_r2: got %h/%b want 0001/1", dout, wb); end
        issue(OP_ADD, C_AL, 1'b1, 5'b00000, 3'd3, 3'd1, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'h8000 || wb !== 1'b1) begin n_bad++; $display("FAIL add_ovf: got %h/%b want 8000/1", dout, wb); end
        n_cmp++; if (nzcv !== 4'b1001) begin n_bad++; $display("FAIL add_ovf_nzcv: got %b want 1001", nzcv); end
        read_reg(3'd3);
        n_cmp++; if (dout !== 16'h8000) begin n_bad++; $display("FAIL r3_readback: got %h want 8000", dout); end
    endtask

    task automatic test_zero_cond;
        issue(OP_SUB, C_AL, 1'b1, 5'b00000, 3'd4, 3'd2, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'h0000 || wb !== 1'b1) begin n_bad++; $display("FAIL sub_zero: got %h/%b want 0000/1", dout, wb); end
        n_cmp++; if (nzcv !== 4'b0110) begin n_bad++; $display("FAIL sub_zero_nzcv: got %b want 0110", nzcv); end
        issue(OP_ADD, C_NE, 1'b0, 5'b00000, 3'd5, 3'd1, 3'd2, 16'h0000);
        n_cmp++; if (wb !== 1'b0) begin n_bad++; $display("FAIL ne_no_wb: got %b want 0", wb); end
        n_cmp++; if (nzcv !== 4'b0110) begin n_bad++; $display("FAIL ne_nzcv: got %b want 0110", nzcv); end
        read_reg(3'd5);
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL ne_r5: got %h want 0000", dout); end
        issue(OP_ADD, C_EQ, 1'b0, 5'b00000, 3'd5, 3'd1, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'h8000 || wb !== 1'b1) begin n_bad++; $display("FAIL eq_add: got %h/%b want 8000/1", dout, wb); end
    endtask

    task automatic test_shifter;
        issue(OP_MOVI, C_AL, 1'b0, 5'b00000, 3'd1, 3'd0, 3'd0, 16'h8000);
        issue(OP_B_PAS, C_AL, 1'b0, 5'b11100, 3'd6, 3'd0, 3'd1, 16'h0000);
        n_cmp++; if (dout !== 16'hF800) begin n_bad++; $display("FAIL asr4: got %h want f800", dout); end
        issue(OP_B_PAS, C_AL, 1'b0, 5'b10000, 3'd6, 3'd0, 3'd1, 16'h0000);
        n_cmp++; if (dout !== 16'hFFFF) begin n_bad++; $display("FAIL asr16: got %h want ffff", dout); end
        issue(OP_MOVI, C_AL, 1'b0, 5'b00000, 3'd1, 3'd0, 3'd0, 16'h0123);
        issue(OP_B_PAS, C_AL, 1'b0, 5'b00100, 3'd6, 3'd0, 3'd1, 16'h0000);
        n_cmp++; if (dout !== 16'h1230) begin n_bad++; $display("FAIL lsl4: got %h want 1230", dout); end
        issue(OP_B_PAS, C_AL, 1'b0, 5'b01111, 3'd6, 3'd0, 3'd1, 16'h0000);
        n_cmp++; if (dout !== 16'h8000) begin n_bad++; $display("FAIL lsl15: got %h want 8000", dout); end
        issue(OP_ADD, C_AL, 1'b0, 5'b00011, 3'd6, 3'd2, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'h0009) begin n_bad++; $display("FAIL add_lsl3: got %h want 0009", dout); end
        issue(OP_B_INV, C_AL, 1'b0, 5'b00000, 3'd6, 3'd0, 3'd1, 16'h0000);
        n_cmp++; if (dout !== 16'hFEDC) begin n_bad++; $display("FAIL b_inv: got %h want fedc", dout); end
        issue(OP_AND, C_AL, 1'b0, 5'b00000, 3'd6, 3'd1, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'h0001) begin n_bad++; $display("FAIL and: got %h want 0001", dout); end
        issue(OP_EOR, C_AL, 1'b0, 5'b00000, 3'd6, 3'd1, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'h0122) begin n_bad++; $display("FAIL eor: got %h want 0122", dout); end
        issue(OP_B_NEG, C_AL, 1'b1, 5'b00000, 3'd6, 3'd0, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'hFFFF || nzcv !== 4'b1000) begin n_bad++; $display("FAIL b_neg: got %h/%b want ffff/1000", dout, nzcv); end
        issue(OP_SUB, C_AL, 1'b1, 5'b00000, 3'd4, 3'd4, 3'd4, 16'h0000);
        issue(OP_ORR, C_AL, 1'b1, 5'b00000, 3'd6, 3'd1, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'h0123 || nzcv !== 4'b0010) begin n_bad++; $display("FAIL orr_keep_c: got %h/%b want 0123/0010", dout, nzcv); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        present(OP_MOVI, C_AL, 1'b0, 5'b00000, 3'd1, 3'd0, 3'd0, 16'h0012);
        @(negedge clk);
        n_cmp++; if (dout !== 16'h0012 || wb !== 1'b1 || ready !== 1'b1) begin n_bad++; $display("FAIL b2b_first: got %h/%b/%b want 0012/1/1", dout, wb, ready); end
        present(OP_MOVI, C_AL, 1'b0, 5'b00000, 3'd2, 3'd0, 3'd0, 16'h0034);
        @(negedge clk);
        valid = 1'b0;
        n_cmp++; if (dout !== 16'h0034 || wb !== 1'b1) begin n_bad++; $display("FAIL b2b_second: got %h/%b want 0034/1", dout, wb); end
        issue(OP_ADD, C_AL, 1'b0, 5'b00000, 3'd3, 3'd1, 3'd2, 16'h0000);
        n_cmp++; if (dout !== 16'h0046) begin n_bad++; $display("FAIL b2b_add: got %h want 0046", dout); end
    endtask

`ifdef ARMISH_MUL_EN
    task automatic test_mul;
        int busy_cycles;
        logic early_wb;
        busy_cycles = 0;
        early_wb = 1'b0;
        issue(OP_SUB, C_AL, 1'b1, 5'b00000, 3'd4, 3'd4, 3'd4, 16'h0000);
        @(negedge clk);
        present(OP_MUL, C_AL, 1'b1, 5'b00000, 3'd5, 3'd1, 3'd2, 16'h0000);
        @(negedge clk);
        valid = 1'b0;
        n_cmp++; if (ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL mul_start: got ready %b busy %b want 0/1", ready, busy); end
        for (int i = 0; i < 40; i++) begin
            if (ready !== 1'b0) break;
            busy_cycles++;
            if (wb !== 1'b0) early_wb = 1'b1;
            if (i == 2) present(OP_MOVI, C_AL, 1'b0, 5'b00000, 3'd7, 3'd0, 3'd0, 16'hBEEF);
            else valid = 1'b0;
            @(negedge clk);
        end
        valid = 1'b0;
        n_cmp++; if (busy_cycles !== 16) begin n_bad++; $display("FAIL mul_busy_len: got %0d want 16", busy_cycles); end
        n_cmp++; if (early_wb !== 1'b0) begin n_bad++; $display("FAIL mul_early_wb: got %b want 0", early_wb); end
        n_cmp++; if (dout !== 16'h03A8 || wb !== 1'b1) begin n_bad++; $display("FAIL mul_result: got %h/%b want 03a8/1", dout, wb); end
        n_cmp++; if (nzcv !== 4'b0010) begin n_bad++; $display("FAIL mul_nzcv: got %b want 0010", nzcv); end
        read_reg(3'd7);
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL movi_while_busy: got %h want 0000", dout); end
        read_reg(3'd5);
        n_cmp++; if (dout !== 16'h03A8) begin n_bad++; $display("FAIL mul_r5: got %h want 03a8", dout); end
    endtask

    task automatic test_reset_mid_mul;
        logic late_wb;
        late_wb = 1'b0;
        @(negedge clk);
        present(OP_MUL, C_AL, 1'b1, 5'b00000, 3'd5, 3'd1, 3'd2, 16'h0000);
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_mul_busy: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b/%b want 1/0", ready, busy); end
        n_cmp++; if (wb !== 1'b0 || dout !== 16'h0000 || nzcv !== 4'b0000) begin n_bad++; $display("FAIL abort_state: got %b/%h/%b want 0/0000/0000", wb, dout, nzcv); end
        repeat (16) begin
            @(negedge clk);
            if (wb !== 1'b0) late_wb = 1'b1;
        end
        n_cmp++; if (late_wb !== 1'b0) begin n_bad++; $display("FAIL abort_late_wb: got %b want 0", late_wb); end
        read_reg(3'd5);
        n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL abort_r5: got %h want 0000", dout); end
    endtask
`else
    task automatic test_mul_disabled;
        issue(OP_MUL, C_AL, 1'b1, 5'b00000, 3'd5, 3'd1, 3'd2, 16'h0000);
        n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL nomul_ready: got %b/%b want 1/0", ready, busy); end
        n_cmp++; if (wb !== 1'b0) begin n_bad++; $display("FAIL nomul_wb: got %b want 0", wb); end
        n_cmp++; if (nzcv !== 4'b0010) begin n_bad++; $display("FAIL nomul_nzcv: got %b want 0010", nzcv); end
        read_reg(3'd5);
        n_cmp++; if (dout !== 16'h8000) begin n_bad++; $display("FAIL nomul_r5: got %h want 8000", dout); end
    endtask
`endif

    initial begin
        valid = 1'b0; op = 4'd0; cond = 4'd0; set_flags = 1'b0; sh = 5'b00000;
        d = 3'd0; n = 3'd0; m = 3'd0; imm = 16'h0000; reset = 1'b1;
        test_reset;
        test_overflow;
        test_zero_cond;
        test_shifter;
        test_back_to_back;
`ifdef ARMISH_MUL_EN
        test_mul;
        test_reset_mid_mul;
`else
        test_mul_disabled;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/armish_datapath_mc.md
# armish_datapath_mc

Parametrised, multi-cycle successor to the ARMish single-cycle datapath. It contains a register file, a barrel shifter on the second operand, an ALU with a latched NZCV flag register, ARM-style conditional execution, an immediate-load op, and an optional iterative multiplier. Instructions are issued through a valid/ready handshake by the sequencer above, which sits between the decoder and this datapath.

## Interface
Parameters:
- WIDTH, 16, datapath and register width (≥4)
- NREGS, 8, register count (power of 2); SEL_W = $clog2(NREGS), SH_W = $clog2(WIDTH)+1 are derived localparams

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- valid  in  1  instruction present this cycle
- ready  out  1  datapath accepts an instruction; issue = valid && ready
- op  in  4  0 ADD, 1 SUB, 2 ORR, 3 AND, 4 EOR, 5 B_NEG, 6 B_INV, 7 B_PAS, 8 MUL, 9 MOVI, 10-15 NOP
- cond  in  4  ARM encoding 0 EQ … 14 AL, 15 NV (never)
- set_flags  in  1  update the flag register on a passing instruction
- sh  in  SH_W signed  shift of Rm; negative values are arithmetic right shifts, positive values are left shifts
- d, n, m  in  SEL_W each  destination and source register selects
- imm  in  WIDTH  MOVI operand
- out  out  WIDTH  last value written back (registered)
- wb  out  1  one-cycle pulse the cycle after a register write
- nzcv  out  4  flag register {N,Z,C,V}
- busy  out  1  multiplier running (equals ~ready)

## Operation
- **Operands**
  - A = R[n]; B = shift(R[m], sh).
  - Left shift by sh ≥ WIDTH gives 0. A right shift fills with the sign bit; sh = −WIDTH gives all-sign.
- **Condition**
  - Evaluated at issue against the current nzcv.
  - A failing condition, NV, or NOP means no register write, no flag change, no wb. It still consumes one cycle.
- **ALU results**
  - ADD, SUB, ORR, AND, EOR, B_NEG, B_INV and B_PAS compute modulo 2^WIDTH.
  - SUB computes A + ~B + 1; C = carry out, meaning no borrow.
  - MOVI writes imm, ignoring A and B.
- **Flags** (only when set_flags and the condition passes)
  - ADD and SUB update N, Z, C and V. V is signed overflow at bit WIDTH−1.
  - B_NEG updates N, Z and C; V is unchanged.
  - Logical ops, B_INV, B_PAS and MOVI update N and Z; C and V are unchanged.
  - MUL updates N and Z; C and V are unchanged.
- **MUL**
  - FSM states: IDLE and MUL.
  - On issue, the FSM latches A, B, d and set_flags, clears the accumulator, loads counter = WIDTH, and moves IDLE→MUL.
  - Each cycle it performs one radix-2 shift-and-add step and decrements the counter.
  - When the counter reaches 0, it writes the low WIDTH bits of the product to R[d], updates the flags, and returns MUL→IDLE.
- Instructions presented while ready = 0 are ignored, not queued.
- Register reads are combinational. A write at edge k is visible to reads in cycle k+1.

## Timing
- **Reset values:** all registers 0, nzcv = 0000, out = 0, wb = 0, busy = 0, FSM IDLE. ready = 1 in the first cycle after reset deasserts.
- **Single-cycle op** issued in cycle t:
  - R[d], out and nzcv update at the end of t.
  - wb = 1 in t+1.
  - ready stays 1, so back-to-back issue is allowed.
- **MUL** issued in cycle t:
  - ready = 0 and busy = 1 during cycles t+1 … t+WIDTH.
  - Writeback happens at the end of t+WIDTH.
  - wb = 1 and ready = 1 in t+WIDTH+1.
- **Reset mid-MUL:** aborts the multiply. There is no writeback and no wb, and the FSM returns to IDLE.
- **Simultaneous reset and valid:** reset wins and the instruction is dropped.

## Configuration
- **ARMISH_MUL_EN defined:** the multiplier and FSM are built as described above.
- **ARMISH_MUL_EN undefined:** op 8 behaves as NOP (single cycle, no write, no flags). ready is tied to 1 and busy to 0, and no FSM, counter or accumulator is instantiated.

## Test plan
All scenarios use WIDTH = 16 and NREGS = 8.
- **Overflow flags:** reset; MOVI R1=0x7FFF; MOVI R2=0x0001; ADD R3=R1+R2 with set_flags and AL -> R3 = 0x8000, nzcv = 1001, wb pulses one cycle after each op.
- **Zero flag and conditions:**
  - SUB R4=R2−R2 with set_flags -> R4 = 0x0000, nzcv = 0110.
  - Then ADD R5=R1+R2 with cond NE -> R5 remains 0, no wb.
  - The same op with cond EQ -> R5 = 0x8000.
- **Shifter:**
  - MOVI R1=0x8000; B_PAS R6 with sh=−4 -> 0xF800; with sh=−16 -> 0xFFFF.
  - MOVI R1=0x0123; B_PAS with sh=4 -> 0x1230.
- **Multiply:**
  - MOVI R1=0x0012; MOVI R2=0x0034; MUL R5=R1*R2 with set_flags -> ready low for 16 cycles, R5 = 0x03A8 at issue+16, wb at issue+17, nzcv N,Z = 00.
  - A valid MOVI R7 presented during busy -> R7 unchanged.
- **Reset mid-MUL:** assert reset in the 5th busy cycle -> R5 = 0, nzcv = 0000, no wb, ready = 1 in the first cycle after reset deasserts.
- **Multiplier compiled out** (ARMISH_MUL_EN undefined): MUL R5 -> ready never drops, R5 unchanged, no wb.
